vip_edge_bbox_locator: RTL and testbench

//  Sink for the binary edge-pixel video stream of the Sobel stage (vsync/href/clken + 1-bit pixel).

---
 rtl/vip_edge_bbox_locator.sv | 168 ++++++++++++++++
 tb/tb_vip_edge_bbox_locator.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/vip_edge_bbox_locator.sv
// rtl/vip_edge_bbox_locator.sv - per-frame edge-pixel count and bounding box of a binary video stream
module vip_edge_bbox_locator #(
    parameter int IMG_W      = 640,
    parameter int IMG_H      = 480,
    parameter int MIN_PIXELS = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        pre_frame_vsync,
    input  logic        pre_frame_href,
    input  logic        pre_frame_clken,
    input  logic        pre_img_bit,
    output logic        box_valid,
    output logic        box_found,
    output logic [10:0] box_x_min,
    output logic [10:0] box_x_max,
    output logic [10:0] box_y_min,
    output logic [10:0] box_y_max,
    output logic [19:0] edge_count
);

    localparam logic [10:0] X_LIMIT = 11'(IMG_W);
    localparam logic [10:0] Y_LAST  = 11'(IMG_H - 1);
    localparam logic [19:0] MIN_CNT = 20'(MIN_PIXELS);
    localparam logic [19:0] CNT_SAT = 20'hFFFFF;

    typedef enum logic {
        S_IDLE,
        S_ACTIVE
    } state_t;

    state_t      state;
    state_t      state_nxt;
    logic        vsync_d;
    logic        href_d;
    logic        vs_rise;
    logic        hr_fall;
    logic [10:0] x_cnt;
    logic [10:0] y_cnt;
    logic [19:0] acc_cnt;
    logic [10:0] acc_x_min;
    logic [10:0] acc_x_max;
    logic [10:0] acc_y_min;
    logic [10:0] acc_y_max;
    logic        do_clear;
    logic        do_publish;
    logic        pix_acc;
    logic        edge_acc;
    logic        line_end;
    logic        frame_found;

    assign vs_rise     = pre_frame_vsync & ~vsync_d;
    assign hr_fall     = href_d & ~pre_frame_href;
    assign frame_found = (acc_cnt >= MIN_CNT);

    // Delayed sync signals for edge detection
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vsync_d <= 1'b0;
            href_d  <= 1'b0;
        end else begin
            vsync_d <= pre_frame_vsync;
            href_d  <= pre_frame_href;
        end
    end

    // Frame state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state and per-cycle control; a frame start overrides a simultaneous final line end
    always_comb begin
        state_nxt  = state;
        do_clear   = 1'b0;
        do_publish = 1'b0;
        pix_acc    = 1'b0;
        line_end   = 1'b0;
        edge_acc   = 1'b0;
        if (vs_rise) begin
            do_clear  = 1'b1;
            state_nxt = S_ACTIVE;
        end else if (state == S_ACTIVE) begin
            pix_acc  = pre_frame_href & pre_frame_clken;
            edge_acc = pix_acc & pre_img_bit & (x_cnt < X_LIMIT);
            if (hr_fall) begin
                line_end = 1'b1;
                if (y_cnt == Y_LAST) begin
                    do_publish = 1'b1;
                    state_nxt  = S_IDLE;
                end
            end
        end
    end

    // Pixel position counters and per-frame accumulators
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            x_cnt     <= '0;
            y_cnt     <= '0;
            acc_cnt   <= '0;
            acc_x_min <= '1;
            acc_x_max <= '0;
            acc_y_min <= '1;
            acc_y_max <= '0;
        end else if (do_clear) begin
            x_cnt     <= '0;
            y_cnt     <= '0;
            acc_cnt   <= '0;
            acc_x_min <= '1;
            acc_x_max <= '0;
            acc_y_min <= '1;
            acc_y_max <= '0;
        end else begin
            if (line_end) begin
                x_cnt <= '0;
                y_cnt <= y_cnt + 11'd1;
            end else if (pix_acc && (x_cnt < X_LIMIT)) begin
                x_cnt <= x_cnt + 11'd1;
            end
            if (edge_acc) begin
                if (acc_cnt != CNT_SAT) begin
                    acc_cnt <= acc_cnt + 20'd1;
                end
                if (x_cnt < acc_x_min) begin
                    acc_x_min <= x_cnt;
                end
                if (x_cnt > acc_x_max) begin
                    acc_x_max <= x_cnt;
                end
                if (y_cnt < acc_y_min) begin
                    acc_y_min <= y_cnt;
                end
                if (y_cnt > acc_y_max) begin
                    acc_y_max <= y_cnt;
                end
            end
        end
    end

    // Result registers, loaded once per completed frame and held until the next one
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            box_valid  <= 1'b0;
            box_found  <= 1'b0;
            box_x_min  <= '0;
            box_x_max  <= '0;
            box_y_min  <= '0;
            box_y_max  <= '0;
            edge_count <= '0;
        end else begin
            box_valid <= do_publish;
            if (do_publish) begin
                box_found  <= frame_found;
                box_x_min  <= frame_found ? acc_x_min : 11'd0;
                box_x_max  <= frame_found ? acc_x_max : 11'd0;
                box_y_min  <= frame_found ? acc_y_min : 11'd0;
                box_y_max  <= frame_found ? acc_y_max : 11'd0;
                edge_count <= acc_cnt;
            end
        end
    end

endmodule

// File: tb/tb_vip_edge_bbox_locator.sv
// tb/tb_vip_edge_bbox_locator.sv - randomized self-checking bench for vip_edge_bbox_locator
module tb_vip_edge_bbox_locator;

    localparam int W  = 8;
    localparam int H  = 4;
    localparam int MP = 2;
    localparam int MAXC = 16;

    logic        clk = 1'b0;
    logic        rst;
    logic        vs;
    logic        hr;
    logic        ce;
    logic        pix;
    logic        box_valid;
    logic        box_found;
    logic [10:0] box_x_min;
    logic [10:0] box_x_max;
    logic [10:0] box_y_min;
    logic [10:0] box_y_max;
    logic [19:0] edge_count;

    int n_checks = 0;
    int n_errors = 0;
    int pulses   = 0;
    int line_len = W;
    logic img [0:H-1][0:MAXC-1];

    vip_edge_bbox_locator #(.IMG_W(W), .IMG_H(H), .MIN_PIXELS(MP)) dut (
        .clk            (clk),
        .rst            (rst),
        .pre_frame_vsync(vs),
        .pre_frame_href (hr),
        .pre_frame_clken(ce),
        .pre_img_bit    (pix),
        .box_valid      (box_valid),
        .box_found      (box_found),
        .box_x_min      (box_x_min),
        .box_x_max      (box_x_max),
        .box_y_min      (box_y_min),
        .box_y_max      (box_y_max),
        .edge_count     (edge_count)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (box_valid === 1'b1) pulses++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic clear_img();
        for (int l = 0; l < H; l++)
            for (int c = 0; c < MAXC; c++) img[l][c] = 1'b0;
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_valid"}, 32'(box_valid), 0);
        check({tag, "_found"}, 32'(box_found), 0);
        check({tag, "_xmin"}, 32'(box_x_min), 0);
        check({tag, "_xmax"}, 32'(box_x_max), 0);
        check({tag, "_ymin"}, 32'(box_y_min), 0);
        check({tag, "_ymax"}, 32'(box_y_max), 0);
        check({tag, "_count"}, 32'(edge_count), 0);
    endtask

    // Reference: count every 1 in columns below both the line length and the image width
    task automatic check_model(input string tag);
        int cnt = 0;
        int xmn = 1 << 30, xmx = -1, ymn = 1 << 30, ymx = -1;
        bit fnd;
        for (int l = 0; l < H; l++)
            for (int c = 0; c < line_len && c < W; c++)
                if (img[l][c]) begin
                    cnt++;
                    xmn = (c < xmn) ? c : xmn;
                    xmx = (c > xmx) ? c : xmx;
                    ymn = (l < ymn) ? l : ymn;
                    ymx = (l > ymx) ? l : ymx;
                end
        fnd = (cnt >= MP);
        check({tag, "_found"}, 32'(box_found), 32'(fnd));
        check({tag, "_xmin"}, 32'(box_x_min), fnd ? 32'(xmn) : 0);
        check({tag, "_xmax"}, 32'(box_x_max), fnd ? 32'(xmx) : 0);
        check({tag, "_ymin"}, 32'(box_y_min), fnd ? 32'(ymn) : 0);
        check({tag, "_ymax"}, 32'(box_y_max), fnd ? 32'(ymx) : 0);
        check({tag, "_count"}, 32'(edge_count), 32'(cnt));
    endtask

    task automatic start_frame();
        @(negedge clk);
        vs = 1'b1;
        repeat (2) @(negedge clk);
        vs = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic send_line(input int l);
        hr = 1'b1;
        for (int c = 0; c < line_len; c++) begin
            while ($urandom_range(0, 2) == 0) begin
                ce  = 1'b0;
                pix = 1'($urandom);
                @(negedge clk);
            end
            ce  = 1'b1;
            pix = img[l][c];
            @(negedge clk);
        end
        ce  = 1'b0;
        pix = 1'b0;
        hr  = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    task automatic send_frame(input int nlines);
        start_frame();
        for (int l = 0; l < nlines; l++) send_line(l);
    endtask

    task automatic full_frame(input string tag);
        int p0 = pulses;
        int t  = 0;
        send_frame(H);
        while (pulses == p0 && t < 20) begin
            @(negedge clk);
            t++;
        end
        check({tag, "_pulse"}, 32'(pulses - p0), 1);
        check_model(tag);
        repeat (3) @(negedge clk);
        check({tag, "_single"}, 32'(pulses - p0), 1);
        check({tag, "_vlow"}, 32'(box_valid), 0);
    endtask

    initial begin
        int p0;
        rst = 1'b1; vs = 1'b0; hr = 1'b0; ce = 1'b0; pix = 1'b0;
        // 1: reset with random inputs
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            vs = 1'($urandom); hr = 1'($urandom); ce = 1'($urandom); pix = 1'($urandom);
            check("rst_valid", 32'(box_valid), 0);
        end
        check_zero("rst");
        vs = 1'b0; hr = 1'b0; ce = 1'b0; pix = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        repeat (5) @(negedge clk);
        check_zero("post_rst");
        check("post_rst_pulses", 32'(pulses), 0);

        // 2: two edges
        clear_img(); line_len = W;
        img[1][2] = 1'b1; img[3][5] = 1'b1;
        full_frame("two_edges");

        // 3: empty frame, then single edge
        clear_img();
        full_frame("empty");
        img[0][7] = 1'b1;
        full_frame("single");

        // 4: over-long lines with edges only beyond the width
        clear_img(); line_len = 10;
        img[0][8] = 1'b1; img[1][9] = 1'b1; img[2][8] = 1'b1; img[3][9] = 1'b1;
        full_frame("beyond_w");

        // 5: aborted frame then a full one
        clear_img(); line_len = W;
        for (int l = 0; l < 2; l++)
            for (int c = 0; c < W; c++) img[l][c] = 1'b1;
        p0 = pulses;
        send_frame(2);
        check("abort_nopulse", 32'(pulses - p0), 0);
        clear_img();
        img[0][0] = 1'b1; img[0][1] = 1'b1;
        full_frame("after_abort");
        check("abort_total", 32'(pulses - p0), 1);

        // 6: reset mid-frame, then an all-ones frame
        clear_img();
        start_frame();
        send_line(0);
        send_line(1);
        hr = 1'b1; ce = 1'b1; pix = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        #1;
        check_zero("mid_rst");
        @(negedge clk);
        hr = 1'b0; ce = 1'b0; pix = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        for (int l = 0; l < H; l++)
            for (int c = 0; c < W; c++) img[l][c] = 1'b1;
        full_frame("all_ones");

        // random frames
        for (int f = 0; f < 6; f++) begin
            int dens = $urandom_range(0, 8);
            clear_img();
            line_len = $urandom_range(W - 2, W + 3);
            for (int l = 0; l < H; l++)
                for (int c = 0; c < MAXC; c++)
                    img[l][c] = ($urandom_range(0, 15) < dens);
            full_frame($sformatf("rand%0d", f));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
